// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared defaults and types for the reg_file_sb register file.
// Optional forwarding is enabled by defining REGFILE_BYPASS_EN.
package reg_file_sb_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_AW    = 5;

  // Number of byte lanes in the default data word.
  localparam int NBYTES = DEF_WIDTH / 8;

  typedef logic [DEF_AW-1:0]    reg_addr_t;
  typedef logic [DEF_WIDTH-1:0] reg_data_t;

  // Address of the optional hardwired zero register.
  localparam int ZERO_ADDR = 0;

endpackage

// File: rtl/reg_file_sb_rport.sv
// reg_file_rport: one asynchronous read port of reg_file_sb.
// Decodes the address, masks out-of-range and hardwired-zero reads, and,
// when REGFILE_BYPASS_EN is defined, forwards a same-cycle write.
module reg_file_rport
  import reg_file_sb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = DEF_AW,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]      ard,
  input  logic [WIDTH-1:0]   mem [DEPTH],
  input  logic [DEPTH-1:0]   pend,
`ifdef REGFILE_BYPASS_EN
  input  logic               we,
  input  logic [AW-1:0]      awr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] be,
  input  logic               set_pend,
  input  logic [AW-1:0]      apend,
`endif
  output logic [WIDTH-1:0]   dout,
  output logic               busy
);

  localparam int            LANES   = WIDTH / 8;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

  logic             addr_ok_s;
  logic [WIDTH-1:0] stored_s;
  logic             stored_busy_s;

  // Qualify the read address: in range and not the hardwired zero register.
  always_comb begin
    if ((ZERO_REG != 0) && (ard == AW'(ZERO_ADDR))) begin
      addr_ok_s = 1'b0;
    end else begin
      addr_ok_s = ({1'b0, ard} < DEPTH_W);
    end
  end

  // One-hot AND-OR mux of the stored word and its pending bit.
  always_comb begin
    stored_s      = '0;
    stored_busy_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      stored_s      = stored_s | ({WIDTH{addr_ok_s && (ard == AW'(i))}} & mem[i]);
      stored_busy_s = stored_busy_s | (addr_ok_s && (ard == AW'(i)) && pend[i]);
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [WIDTH-1:0] lane_mask_s;
  logic             fwd_s;

  // Forward a write targeting this address, merged lane by lane.
  always_comb begin
    lane_mask_s = '0;
    for (int b = 0; b < LANES; b++) begin
      lane_mask_s[8*b +: 8] = {8{be[b]}};
    end
    fwd_s = we && addr_ok_s && (awr == ard);
    if (fwd_s) begin
      dout = (wdata & lane_mask_s) | (stored_s & ~lane_mask_s);
      busy = set_pend && (apend == ard);
    end else begin
      dout = stored_s;
      busy = stored_busy_s;
    end
  end
`else
  // Without forwarding the port shows pre-edge state only.
  always_comb begin
    dout = stored_s;
    busy = stored_busy_s;
  end
`endif

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: DEPTH x WIDTH register file with two async read ports, one
// byte-enabled write port and a per-register pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = DEF_AW,
  parameter int ZERO_REG = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [AW-1:0]      Ard1,
  input  logic [AW-1:0]      Ard2,
  output logic [WIDTH-1:0]   Dout1,
  output logic [WIDTH-1:0]   Dout2,
  output logic               Busy1,
  output logic               Busy2,
  input  logic               WE,
  input  logic [AW-1:0]      Awr,
  input  logic [WIDTH-1:0]   Data,
  input  logic [WIDTH/8-1:0] BE,
  input  logic               SetPend,
  input  logic [AW-1:0]      Apend,
  output logic               AnyBusy
);

  localparam int          LANES   = WIDTH / 8;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] pend_r;
  logic [DEPTH-1:0] pend_next_s;
  logic [DEPTH-1:0] wr_hit_s;
  logic [DEPTH-1:0] set_hit_s;
  logic             wr_ok_s;
  logic             set_ok_s;

  // Writes and issues to out-of-range or hardwired-zero registers are dropped.
  always_comb begin
    if ((ZERO_REG != 0) && (Awr == AW'(ZERO_ADDR))) begin
      wr_ok_s = 1'b0;
    end else begin
      wr_ok_s = WE && ({1'b0, Awr} < DEPTH_W);
    end
    if ((ZERO_REG != 0) && (Apend == AW'(ZERO_ADDR))) begin
      set_ok_s = 1'b0;
    end else begin
      set_ok_s = SetPend && ({1'b0, Apend} < DEPTH_W);
    end
  end

  // Per-register write/issue decode and next pending state (issue beats writeback).
  always_comb begin
    wr_hit_s    = '0;
    set_hit_s   = '0;
    pend_next_s = pend_r;
    for (int i = 0; i < DEPTH; i++) begin
      wr_hit_s[i]  = wr_ok_s  && (Awr   == AW'(i));
      set_hit_s[i] = set_ok_s && (Apend == AW'(i));
      if (set_hit_s[i]) begin
        pend_next_s[i] = 1'b1;
      end else if (wr_hit_s[i]) begin
        pend_next_s[i] = 1'b0;
      end else begin
        pend_next_s[i] = pend_r[i];
      end
    end
  end

  // Storage and scoreboard update; reset discards any same-cycle write or issue.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      pend_r <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int b = 0; b < LANES; b++) begin
          if (wr_hit_s[i] && BE[b]) begin
            mem_r[i][8*b +: 8] <= Data[8*b +: 8];
          end
        end
      end
      pend_r <= pend_next_s;
    end
  end

  assign AnyBusy = |pend_r;

  reg_file_rport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)
  ) u_rport1 (
    .ard      (Ard1),
    .mem      (mem_r),
    .pend     (pend_r),
`ifdef REGFILE_BYPASS_EN
    .we       (WE),
    .awr      (Awr),
    .wdata    (Data),
    .be       (BE),
    .set_pend (SetPend),
    .apend    (Apend),
`endif
    .dout     (Dout1),
    .busy     (Busy1)
  );

  reg_file_rport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)
  ) u_rport2 (
    .ard      (Ard2),
    .mem      (mem_r),
    .pend     (pend_r),
`ifdef REGFILE_BYPASS_EN
    .we       (WE),
    .awr      (Awr),
    .wdata    (Data),
    .be       (BE),
    .set_pend (SetPend),
    .apend    (Apend),
`endif
    .dout     (Dout2),
    .busy     (Busy2)
  );

endmodule
